// File: rtl/zclk_pkg.sv
// Shared definitions for the Z80 clock-phase controller: turbo encodings,
// turbo-FSM states and default timeout sizing.
package zclk_pkg;

    localparam logic [1:0] T35  = 2'b00;
    localparam logic [1:0] T70  = 2'b01;
    localparam logic [1:0] T140 = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } turbo_state_e;

    localparam int TIMEOUT_DEF = 4096;
    localparam int TO_W_DEF    = 13;

    // One-hot strobe vector for a 2-bit phase value.
    function automatic logic [3:0] phase_onehot(input logic [1:0] phase);
        return 4'b0001 << phase;
    endfunction

endpackage

// File: rtl/zclk_phase_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous active-low strobes; resets to all ones
// so every strobe reads as inactive until real samples arrive.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/zclk_phase_ctrl.sv
// Z80 clock-generator front end: 7 MHz phase strobes, control-strobe resync,
// iorq_s pulse and the refresh-gated effective turbo setting.
module zclk_phase_ctrl
    import zclk_pkg::*;
#(
    parameter logic [1:0] TURBO_RST = T35,
    parameter int         TIMEOUT   = TIMEOUT_DEF,
    parameter int         TO_W      = TO_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       zpos,
    input  logic       rfsh_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic [1:0] turbo_req,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic [1:0] turbo,
    output logic       turbo_sw,
    output logic       iorq_s
);

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TIMER_MAX  = '1;

    logic [3:0] strobes_s;
    logic       rfsh_n_s;
    logic       mreq_n_s;
    logic       iorq_n_s;
    logic       m1_n_s;

    sync2 #(.W(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({rfsh_n, mreq_n, iorq_n, m1_n}),
        .q     (strobes_s)
    );

    assign {rfsh_n_s, mreq_n_s, iorq_n_s, m1_n_s} = strobes_s;

    logic [1:0]      phase_q,     phase_d;
    logic [3:0]      c_q,         c_d;
    logic            iorq_prev_q, iorq_prev_d;
    logic            iorq_s_q,    iorq_s_d;
    turbo_state_e    state_q,     state_d;
    logic [TO_W-1:0] timer_q,     timer_d;
    logic [1:0]      turbo_q,     turbo_d;
    logic            turbo_sw_q,  turbo_sw_d;
    logic            refr;

    always_comb begin
        phase_d     = phase_q + 2'd1;
        c_d         = phase_onehot(phase_d);
        iorq_prev_d = iorq_n_s;
        // INTA cycles (M1 low) must not look like ordinary I/O accesses.
        iorq_s_d    = iorq_prev_q & ~iorq_n_s & m1_n_s;
    end

    assign refr = zpos & ~rfsh_n_s & ~mreq_n_s;

    // Turbo only moves during a refresh cycle (or on timeout) so the clock
    // generator never sees a change mid-access; the live request always wins.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        turbo_d    = turbo_q;
        turbo_sw_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (turbo_req != turbo_q) begin
                    timer_d = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                if (turbo_req == turbo_q) begin
                    state_d = ST_IDLE;
                end else if (refr || (timer_q == TIMER_LAST)) begin
                    turbo_d    = turbo_req;
                    turbo_sw_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 2'd3;
            c_q         <= '0;
            iorq_prev_q <= 1'b1;
            iorq_s_q    <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            turbo_q     <= TURBO_RST;
            turbo_sw_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            c_q         <= c_d;
            iorq_prev_q <= iorq_prev_d;
            iorq_s_q    <= iorq_s_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            turbo_q     <= turbo_d;
            turbo_sw_q  <= turbo_sw_d;
        end
    end

    assign c0       = c_q[0];
    assign c1       = c_q[1];
    assign c2       = c_q[2];
    assign c3       = c_q[3];
    assign turbo    = turbo_q;
    assign turbo_sw = turbo_sw_q;
    assign iorq_s   = iorq_s_q;

endmodule

// File: tb/tb_zclk_phase_ctrl.sv
// Bench for zclk_phase_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a sample-history reference model.
module tb_zclk_phase_ctrl;

    localparam logic [1:0] TRST = 2'b00;
    localparam int         TO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zpos = 1'b0;
    logic       rfsh_n = 1'b1;
    logic       mreq_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       m1_n = 1'b1;
    logic [1:0] turbo_req = 2'b00;
    logic       c0, c1, c2, c3;
    logic [1:0] turbo;
    logic       turbo_sw;
    logic       iorq_s;

    always #5 clk = ~clk;

    zclk_phase_ctrl #(.TURBO_RST(TRST), .TIMEOUT(TO), .TO_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .zpos      (zpos),
        .rfsh_n    (rfsh_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .m1_n      (m1_n),
        .turbo_req (turbo_req),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .turbo     (turbo),
        .turbo_sw  (turbo_sw),
        .iorq_s    (iorq_s)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: raw samples per edge; the design sees each strobe as
    // the value sampled two edges earlier.
    typedef struct packed {
        logic rfsh;
        logic mreq;
        logic iorq;
        logic m1;
    } smp_t;

    smp_t       hist[$];
    smp_t       s_m, p_m, new_m;
    int         m_n = 0;
    logic [1:0] m_turbo = TRST;
    bit         m_sw = 0;
    bit         m_iorq = 0;
    bit         m_armed = 0;
    int         m_timer = 0;
    bit         m_refr;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_n = 0; m_turbo = TRST; m_sw = 0; m_iorq = 0;
            m_armed = 0; m_timer = 0;
            hist.delete();
        end else begin
            s_m = '1;
            p_m = '1;
            if (hist.size() > 1) s_m = hist[1];
            if (hist.size() > 2) p_m = hist[2];
            m_n++;
            m_refr = zpos && !s_m.rfsh && !s_m.mreq;
            m_sw = 0;
            if (!m_armed) begin
                if (turbo_req != m_turbo) begin
                    m_armed = 1;
                    m_timer = 0;
                end
            end else if (turbo_req == m_turbo) begin
                m_armed = 0;
            end else if (m_refr || m_timer == TO - 1) begin
                m_turbo = turbo_req;
                m_sw = 1;
                m_armed = 0;
            end else begin
                m_timer++;
            end
            m_iorq = !s_m.iorq && p_m.iorq && s_m.m1;
            new_m.rfsh = rfsh_n;
            new_m.mreq = mreq_n;
            new_m.iorq = iorq_n;
            new_m.m1   = m1_n;
            hist.push_front(new_m);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    int sw_cnt = 0;
    int io_cnt = 0;
    int exp_c;

    initial forever begin
        @(negedge clk);
        exp_c = (m_n == 0) ? 0 : (1 << ((m_n - 1) % 4));
        check("phase", int'({c3, c2, c1, c0}), exp_c);
        check("turbo", int'(turbo), int'(m_turbo));
        check("turbo_sw", int'(turbo_sw), int'(m_sw));
        check("iorq_s", int'(iorq_s), int'(m_iorq));
        if (turbo_sw) sw_cnt++;
        if (iorq_s) io_cnt++;
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_turbo(input logic [1:0] v, input int maxe, output int edges);
        edges = 0;
        while (turbo !== v && edges < maxe) begin
            tick(1);
            edges++;
        end
    endtask

    task automatic refresh_strobe(output int lat);
        rfsh_n = 1'b0;
        mreq_n = 1'b0;
        wait_turbo(2'b10, 10, lat);
        rfsh_n = 1'b1;
        mreq_n = 1'b1;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        turbo_req = TRST;
        tick(2);
        rst_n = 1'b1;
    endtask

    int base, e, first;

    initial begin
        tick(2);
        rst_n = 1'b1;
        base = sw_cnt;
        tick(1);
        check("c0_first_edge", int'({c3, c2, c1, c0}), 1);
        tick(15);
        check("no_sw_after_reset", sw_cnt - base, 0);
        $display("reset release: free-run done");

        zpos = 1'b1;
        turbo_req = 2'b10;
        tick(10);
        check("hold_without_refr", int'(turbo), 0);
        base = sw_cnt;
        refresh_strobe(e);
        check("refr_latency", e, 3);
        tick(4);
        check("refr_single_sw", sw_cnt - base, 1);
        $display("refresh switch 00->10 latency %0d", e);

        pulse_reset();
        base = sw_cnt;
        turbo_req = 2'b01;
        tick(3);
        turbo_req = 2'b10;
        tick(3);
        refresh_strobe(e);
        check("latest_req_latency", e, 3);
        tick(4);
        check("latest_req_single_sw", sw_cnt - base, 1);
        check("latest_req_value", int'(turbo), 2);
        $display("req 01->10 then refresh: turbo=%0d", turbo);

        pulse_reset();
        base = sw_cnt;
        turbo_req = 2'b01;
        tick(2);
        turbo_req = 2'b00;
        tick(20);
        check("withdrawn_turbo", int'(turbo), 0);
        check("withdrawn_no_sw", sw_cnt - base, 0);
        $display("req 01->00 withdrawn: turbo=%0d", turbo);

        base = sw_cnt;
        turbo_req = 2'b01;
        wait_turbo(2'b01, 40, e);
        check("timeout_after_arm", e - 1, 16);
        tick(2);
        check("timeout_single_sw", sw_cnt - base, 1);
        $display("timeout switch after %0d clk armed", e - 1);

        base = io_cnt;
        first = -1;
        iorq_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (iorq_s && first < 0) first = i;
        end
        iorq_n = 1'b1;
        check("iorq_latency", first, 3);
        check("iorq_single_pulse", io_cnt - base, 1);
        tick(4);
        base = io_cnt;
        m1_n = 1'b0;
        iorq_n = 1'b0;
        tick(10);
        iorq_n = 1'b1;
        m1_n = 1'b1;
        tick(4);
        check("inta_no_pulse", io_cnt - base, 0);
        $display("iorq pulse latency %0d, INTA quiet", first);

        turbo_req = 2'b10;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_turbo", int'(turbo), int'(TRST));
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rearm_holds", int'(turbo), int'(TRST));
        refresh_strobe(e);
        check("rearm_refr_latency", e, 3);
        $display("reset while armed: re-armed, switched after %0d", e);

        for (int i = 0; i < 3000; i++) begin
            tick(1);
            zpos = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) rfsh_n = ~rfsh_n;
            if ($urandom_range(0, 5) == 0) mreq_n = ~mreq_n;
            if ($urandom_range(0, 9) == 0) iorq_n = ~iorq_n;
            if ($urandom_range(0, 9) == 0) m1_n = ~m1_n;
            if ($urandom_range(0, 39) == 0) turbo_req = 2'($urandom_range(0, 3));
        end
        tick(2);
        $display("random phase done, turbo pulses %0d, iorq pulses %0d", sw_cnt, io_cnt);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
